// File: rtl/uart_core_param.sv
// Parametrised UART: TX and RX engines sharing one 16x oversampling baud tick,
// with configurable width, parity, stop bits and a runtime loopback mux.
module uart_core_param #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 loopback,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 txd,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err
);

    localparam int   DIV     = CLK_FREQ / (BAUD * 16);
    localparam int   DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic PAR_ODD = (PARITY == 2);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_core_param: DATA_BITS must be 5..9");
    end
    if (DIV < 1) begin : g_bad_div
        $error("uart_core_param: CLK_FREQ too low for BAUD*16");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_core_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_core_param: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

    logic [DIV_W-1:0] div_cnt_reg;
    logic             tick;

    assign tick = (div_cnt_reg == DIV_W'(DIV - 1));

    always_ff @(posedge clk or posedge arst) begin
        if (arst)      div_cnt_reg <= '0;
        else if (tick) div_cnt_reg <= '0;
        else           div_cnt_reg <= div_cnt_reg + DIV_W'(1);
    end

    // ---------------- transmitter ----------------
    state_t               tx_state_reg;
    logic [3:0]           tx_tick_reg;
    logic [3:0]           tx_bit_reg;
    logic [DATA_BITS-1:0] tx_shift_reg;
    logic                 tx_par_reg;
    logic                 tx_line_reg;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            tx_state_reg <= ST_IDLE;
            tx_tick_reg  <= '0;
            tx_bit_reg   <= '0;
            tx_shift_reg <= '0;
            tx_par_reg   <= 1'b0;
            tx_line_reg  <= 1'b1;
            tx_busy      <= 1'b0;
            tx_done      <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (tx_state_reg == ST_IDLE) begin
                if (tx_start) begin
                    tx_shift_reg <= tx_data;
                    tx_par_reg   <= (^tx_data) ^ PAR_ODD;
                    tx_line_reg  <= 1'b0;
                    tx_busy      <= 1'b1;
                    tx_tick_reg  <= '0;
                    tx_state_reg <= ST_START;
                end
            end else if (tick) begin
                if (tx_tick_reg != 4'd15) begin
                    tx_tick_reg <= tx_tick_reg + 4'd1;
                end else begin
                    tx_tick_reg <= '0;
                    case (tx_state_reg)
                        ST_START: begin
                            tx_line_reg  <= tx_shift_reg[0];
                            tx_shift_reg <= tx_shift_reg >> 1;
                            tx_bit_reg   <= '0;
                            tx_state_reg <= ST_DATA;
                        end
                        ST_DATA: begin
                            if (tx_bit_reg == 4'(DATA_BITS - 1)) begin
                                tx_bit_reg <= '0;
                                if (PARITY != 0) begin
                                    tx_line_reg  <= tx_par_reg;
                                    tx_state_reg <= ST_PARITY;
                                end else begin
                                    tx_line_reg  <= 1'b1;
                                    tx_state_reg <= ST_STOP;
                                end
                            end else begin
                                tx_bit_reg   <= tx_bit_reg + 4'd1;
                                tx_line_reg  <= tx_shift_reg[0];
                                tx_shift_reg <= tx_shift_reg >> 1;
                            end
                        end
                        ST_PARITY: begin
                            tx_line_reg  <= 1'b1;
                            tx_bit_reg   <= '0;
                            tx_state_reg <= ST_STOP;
                        end
                        ST_STOP: begin
                            if (tx_bit_reg == 4'(STOP_BITS - 1)) begin
                                tx_busy      <= 1'b0;
                                tx_done      <= 1'b1;
                                tx_state_reg <= ST_IDLE;
                            end else begin
                                tx_bit_reg <= tx_bit_reg + 4'd1;
                            end
                        end
                        default: tx_state_reg <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    // In loopback the pin idles high while the frame goes straight to RX.
    assign txd = loopback | tx_line_reg;

    // ---------------- receiver ----------------
    logic                 rx_src;
    logic [1:0]           rx_sync_reg;
    logic                 rx_line;
    state_t               rx_state_reg;
    logic [3:0]           rx_tick_reg;
    logic [3:0]           rx_bit_reg;
    logic [DATA_BITS-1:0] rx_shift_reg;
    logic                 rx_perr_reg;
    logic                 rx_ferr_reg;

    assign rx_src  = loopback ? tx_line_reg : rxd;
    assign rx_line = rx_sync_reg[1];

    always_ff @(posedge clk or posedge arst) begin
        if (arst) rx_sync_reg <= 2'b11;
        else      rx_sync_reg <= {rx_sync_reg[0], rx_src};
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rx_state_reg  <= ST_IDLE;
            rx_tick_reg   <= '0;
            rx_bit_reg    <= '0;
            rx_shift_reg  <= '0;
            rx_perr_reg   <= 1'b0;
            rx_ferr_reg   <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (tick) begin
                case (rx_state_reg)
                    ST_IDLE: begin
                        if (!rx_line) begin
                            rx_tick_reg  <= '0;
                            rx_state_reg <= ST_START;
                        end
                    end
                    ST_START: begin
                        // Mid-start check filters glitches shorter than half a bit.
                        if (rx_tick_reg == 4'd7) begin
                            rx_tick_reg  <= '0;
                            rx_bit_reg   <= '0;
                            rx_perr_reg  <= 1'b0;
                            rx_ferr_reg  <= 1'b0;
                            rx_state_reg <= rx_line ? ST_IDLE : ST_DATA;
                        end else begin
                            rx_tick_reg <= rx_tick_reg + 4'd1;
                        end
                    end
                    default: begin
                        if (rx_tick_reg != 4'd15) begin
                            rx_tick_reg <= rx_tick_reg + 4'd1;
                        end else begin
                            rx_tick_reg <= '0;
                            case (rx_state_reg)
                                ST_DATA: begin
                                    rx_shift_reg <= {rx_line, rx_shift_reg[DATA_BITS-1:1]};
                                    if (rx_bit_reg == 4'(DATA_BITS - 1)) begin
                                        rx_bit_reg   <= '0;
                                        rx_state_reg <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                                    end else begin
                                        rx_bit_reg <= rx_bit_reg + 4'd1;
                                    end
                                end
                                ST_PARITY: begin
                                    rx_perr_reg  <= rx_line ^ (^rx_shift_reg) ^ PAR_ODD;
                                    rx_state_reg <= ST_STOP;
                                end
                                ST_STOP: begin
                                    if (rx_bit_reg == 4'(STOP_BITS - 1)) begin
                                        rx_data       <= rx_shift_reg;
                                        rx_valid      <= 1'b1;
                                        rx_parity_err <= rx_perr_reg;
                                        rx_frame_err  <= rx_ferr_reg | ~rx_line;
                                        rx_state_reg  <= ST_IDLE;
                                    end else begin
                                        rx_ferr_reg <= rx_ferr_reg | ~rx_line;
                                        rx_bit_reg  <= rx_bit_reg + 4'd1;
                                    end
                                end
                                default: rx_state_reg <= ST_IDLE;
                            endcase
                        end
                    end
                endcase
            end
        end
    end

endmodule
